// File: rtl/gate_full_adder.sv
// Ripple-carry full adder built from per-bit gate equations, with a registered copy of the result.
// Optional macro GATE_FULL_ADDER_OVF_EN adds signed-overflow outputs ovf/ovf_q.
module gate_full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q
`ifdef GATE_FULL_ADDER_OVF_EN
  ,
  output logic             ovf,
  output logic             ovf_q
`endif
);

  // c[i] is the carry into cell i; c[WIDTH] leaves the MSB cell.
  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[WIDTH];

`ifdef GATE_FULL_ADDER_OVF_EN
  // Signed overflow: carry into the sign cell differs from carry out of it.
  assign ovf = c[WIDTH] ^ c[WIDTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf;
    end
  end
`endif

  // Reset clears only the registered copy; sum/cout keep tracking the inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
    end
  end

endmodule

// File: tb/tb_gate_full_adder.sv
// Bench for gate_full_adder: 1-bit truth table, combinational timing, registered path,
// asynchronous reset, and a 4-bit instance with directed and random vectors.
module tb_gate_full_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic       sum1, cout1, sum1_q, cout1_q;
  logic [3:0] a4 = '0, b4 = '0;
  logic       cin4 = 1'b0;
  logic [3:0] sum4, sum4_q;
  logic       cout4, cout4_q;
`ifdef GATE_FULL_ADDER_OVF_EN
  logic       ovf1, ovf1_q, ovf4, ovf4_q;
`endif

  gate_full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .cout(cout1), .sum_q(sum1_q), .cout_q(cout1_q)
`ifdef GATE_FULL_ADDER_OVF_EN
    , .ovf(ovf1), .ovf_q(ovf1_q)
`endif
  );

  gate_full_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .a(a4), .b(b4), .cin(cin4),
    .sum(sum4), .cout(cout4), .sum_q(sum4_q), .cout_q(cout4_q)
`ifdef GATE_FULL_ADDER_OVF_EN
    , .ovf(ovf4), .ovf_q(ovf4_q)
`endif
  );

  // ---------------- scoreboard ----------------
  int passed = 0;
  int total  = 0;
  logic [1:0] exp1_q[$];   // {cout, sum} for the 1-bit instance
  logic [4:0] exp4_q[$];   // {cout, sum} for the 4-bit instance

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic a, b, cin;
    logic sum, cout;
  } vec1_t;

  typedef struct {
    logic [3:0] a, b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
  } vec4_t;

  vec1_t tt[8];
  vec4_t dv[4];

  // ---------------- driver tasks ----------------
  // Drive on the falling edge, check the combinational result, then the registered one.
  task automatic drive1(input logic a, input logic b, input logic cin, input logic [1:0] exp);
    logic [1:0] e;
    @(negedge clk);
    a1 = a; b1 = b; cin1 = cin;
    exp1_q.push_back(exp);
    #1;
    check("comb1", {6'b0, cout1, sum1}, {6'b0, exp});
    @(posedge clk);
    #1;
    e = exp1_q.pop_front();
    check("reg1", {6'b0, cout1_q, sum1_q}, {6'b0, e});
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        input logic [4:0] exp);
    logic [4:0] e;
    @(negedge clk);
    a4 = a; b4 = b; cin4 = cin;
    exp4_q.push_back(exp);
    #1;
    check("comb4", {3'b0, cout4, sum4}, {3'b0, exp});
`ifdef GATE_FULL_ADDER_OVF_EN
    begin
      int r;
      r = $signed(a) + $signed(b) + int'(cin);
      check("ovf4", {7'b0, ovf4}, {7'b0, (r > 7 || r < -8)});
    end
`endif
    @(posedge clk);
    #1;
    e = exp4_q.pop_front();
    check("reg4", {3'b0, cout4_q, sum4_q}, {3'b0, e});
  endtask

  // ---------------- test ----------------
  initial begin
    tt[0] = '{0,0,0, 0,0}; tt[1] = '{0,0,1, 1,0};
    tt[2] = '{0,1,0, 1,0}; tt[3] = '{0,1,1, 0,1};
    tt[4] = '{1,0,0, 1,0}; tt[5] = '{1,0,1, 0,1};
    tt[6] = '{1,1,0, 0,1}; tt[7] = '{1,1,1, 1,1};
    dv[0] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1};
    dv[1] = '{4'h7, 4'h8, 1'b1, 4'h0, 1'b1};
    dv[2] = '{4'h3, 4'h4, 1'b0, 4'h7, 1'b0};
    dv[3] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};

    // Reset state: registered outputs held at zero.
    #1;
    check("rst_sum_q", {7'b0, sum1_q}, 8'h0);
    check("rst_cout_q", {7'b0, cout1_q}, 8'h0);
    check("rst_sum4_q", {4'b0, sum4_q}, 8'h0);
    @(negedge clk);
    reset = 1'b1;

    // Exhaustive 1-bit truth table.
    for (int i = 0; i < 8; i++)
      drive1(tt[i].a, tt[i].b, tt[i].cin, {tt[i].cout, tt[i].sum});

    // Combinational timing: mid-cycle change, no clock edge in between.
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; cin1 = 1'b0;
    #1;
    a1 = 1'b1;
    #1;
    check("mid_sum", {7'b0, sum1}, 8'h0);
    check("mid_cout", {7'b0, cout1}, 8'h1);
    check("mid_hold_q", {6'b0, cout1_q, sum1_q}, 8'h3);  // still 111 result

    // Registered path: prior value held until the edge.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1;
    #1;
    check("pre_edge_q", {6'b0, cout1_q, sum1_q}, 8'h2);  // 110 captured last edge
    @(posedge clk);
    #1;
    check("post_edge_q", {6'b0, cout1_q, sum1_q}, 8'h2);  // 101 -> sum 0, cout 1

    // Async reset with sum_q = 1.
    drive1(1'b0, 1'b0, 1'b1, 2'b01);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_sum_q", {7'b0, sum1_q}, 8'h0);
    check("async_cout_q", {7'b0, cout1_q}, 8'h0);
    check("rst_comb_sum", {7'b0, sum1}, 8'h1);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    #1;
    check("rst_comb_track", {6'b0, cout1, sum1}, 8'h2);
    @(posedge clk);
    #1;
    check("rst_hold_q", {6'b0, cout1_q, sum1_q}, 8'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_q", {6'b0, cout1_q, sum1_q}, 8'h2);

    // 4-bit directed vectors.
    for (int i = 0; i < 4; i++)
      drive4(dv[i].a, dv[i].b, dv[i].cin, {dv[i].cout, dv[i].sum});

`ifdef GATE_FULL_ADDER_OVF_EN
    @(negedge clk);
    a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0;
    #1;
    check("ovf_7p1", {7'b0, ovf4}, 8'h1);
    a4 = 4'hF;
    #1;
    check("ovf_Fp1", {7'b0, ovf4}, 8'h0);
`endif

    // 4-bit random vectors against an arithmetic model.
    for (int i = 0; i < 24; i++) begin
      logic [3:0] ra, rb;
      logic       rc;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      drive4(ra, rb, rc, 5'(ra) + 5'(rb) + 5'(rc));
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gate_full_adder.md
Name: gate_full_adder

Overview:
- Gate-level ripple-carry full adder.
- Default WIDTH=1 is a classic single-bit full adder with purely combinational sum/cout outputs.
- Also provides a registered copy of the result (sum_q/cout_q) for downstream pipelined consumers; clk/reset affect only that registered copy.
- Leaf arithmetic cell for datapath blocks and gate-level exercises.

Parameters:
- WIDTH, 1, operand width in bits (>=1); ripple chain of WIDTH 1-bit full-adder cells.

Ports:
- clk  input  1  clock; rising edge updates registered outputs only.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted); clears registered outputs only.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in into bit 0.
- sum  output  WIDTH  combinational sum, a + b + cin modulo 2^WIDTH.
- cout  output  1  combinational carry-out of MSB cell.
- sum_q  output  WIDTH  sum registered on rising clk.
- cout_q  output  1  cout registered on rising clk.

Behaviour:
- Each bit cell i, built from explicit gate primitives or equivalent bitwise expressions, no "+" operator:
  - s[i] = a[i] ^ b[i] ^ c[i].
  - c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]).
  - c[0] = cin; cout = c[WIDTH].
- Net result: {cout, sum} = a + b + cin, exact, WIDTH+1 bits; no saturation.
- sum/cout are zero-latency combinational:
  - Valid within the same cycle the inputs change.
  - Independent of clk and reset; unaffected by reset assertion.
- 1-bit truth table, inputs (a, b, cin) -> (sum, cout):
  - 000 -> 0 0
  - 001 -> 1 0
  - 010 -> 1 0
  - 011 -> 0 1
  - 100 -> 1 0
  - 101 -> 0 1
  - 110 -> 0 1
  - 111 -> 1 1
- Registered outputs, latency 1 cycle:
  - sum_q/cout_q capture sum/cout at each rising clk.
- Reset:
  - While reset = 0: sum_q = 0 and cout_q = 0 immediately, without waiting for clk.
  - Capture resumes on the first rising clk after reset deasserts.
  - Reset asserted mid-operation clears the registers at once; combinational outputs keep tracking inputs.
- No internal state beyond sum_q/cout_q; no handshake; every input is accepted every cycle.
- X/Z on inputs is not handled specially.

Optional Feature:
- Macro: GATE_FULL_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit, combinational) = c[WIDTH] ^ c[WIDTH-1], i.e. two's-complement signed overflow.
  - For WIDTH=1, c[WIDTH-1] is cin.
  - Adds registered ovf_q, captured like sum_q and cleared to 0 by reset.
- When undefined: ports ovf/ovf_q do not exist; all other behaviour identical.

Test Plan:
- Exhaustive 1-bit: apply all 8 (a, b, cin) combinations in order 000..111, hold each ~8 time units, check the sum/cout truth table above, e.g. 011 -> sum=0 cout=1, 111 -> sum=1 cout=1.
- Combinational timing: change a from 0 to 1 with b=1, cin=0 mid-cycle, no clk edge -> sum=0, cout=1 before the next edge.
- Registered path: a=1, b=0, cin=1, then one rising clk -> sum_q=0, cout_q=1; before that edge sum_q/cout_q keep prior values.
- Async reset: with sum_q=1, drive reset=0 between edges -> sum_q=0, cout_q=0 immediately; sum/cout still follow inputs. Release reset; the next edge captures current values.
- WIDTH=4: a=4'hF, b=4'h1, cin=0 -> sum=4'h0, cout=1. a=4'h7, b=4'h8, cin=1 -> sum=4'h0, cout=1.
- With GATE_FULL_ADDER_OVF_EN, WIDTH=4:
  - a=4'h7, b=4'h1, cin=0 -> ovf=1.
  - a=4'hF, b=4'h1, cin=0 -> ovf=0.
